// File: rtl/fetch_stage.sv
// IF stage: PC register, direct-mapped BTB with 2-bit counters, IF/ID register. Fetch-to-ID latency 1 cycle.
// Backpressure: PC_stall holds the PC, IF_ID_stall holds IF/ID; a redirect beats PC_stall, a flush beats IF_ID_stall.
module fetch_stage #(
  parameter int                   PC_WIDTH    = 16,
  parameter int                   BTB_ENTRIES = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [15:0]          NOP_INSTR   = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PC_stall,
  input  logic                IF_ID_stall,
  input  logic                IF_flush,
  input  logic                update_PC,
  input  logic [PC_WIDTH-1:0] actual_target,
  input  logic                ID_branch_valid,
  input  logic [PC_WIDTH-1:0] ID_PC,
  input  logic                ID_taken,
  input  logic [PC_WIDTH-1:0] ID_branch_target,
  input  logic [15:0]         imem_instr,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [PC_WIDTH-1:0] IF_ID_PC,
  output logic [PC_WIDTH-1:0] IF_ID_PC_plus2,
  output logic [15:0]         IF_ID_instr,
  output logic                IF_ID_pred_taken,
  output logic [PC_WIDTH-1:0] IF_ID_pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 1;
  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(2);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [PC_WIDTH-1:0] if_id_pc2_q, if_id_pc2_d;
  logic [15:0]         if_id_instr_q, if_id_instr_d;
  logic                if_id_pred_taken_q, if_id_pred_taken_d;
  logic [PC_WIDTH-1:0] if_id_pred_target_q, if_id_pred_target_d;

  logic                btb_valid_q  [BTB_ENTRIES];
  logic                btb_valid_d  [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag_d    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0] btb_target_q [BTB_ENTRIES];
  logic [PC_WIDTH-1:0] btb_target_d [BTB_ENTRIES];
  logic [1:0]          btb_ctr_q    [BTB_ENTRIES];
  logic [1:0]          btb_ctr_d    [BTB_ENTRIES];

  logic [IDX_W-1:0]    fetch_idx, upd_idx;
  logic [TAG_W-1:0]    fetch_tag, upd_tag;
  logic                fetch_hit, upd_hit, pred_taken;
  logic [PC_WIDTH-1:0] pc_plus2, pred_next;
  logic                unused_id_pc_lsb;

  assign unused_id_pc_lsb = ID_PC[0];

  assign fetch_idx  = pc_q[IDX_W:1];
  assign fetch_tag  = pc_q[PC_WIDTH-1:IDX_W+1];
  assign upd_idx    = ID_PC[IDX_W:1];
  assign upd_tag    = ID_PC[PC_WIDTH-1:IDX_W+1];

  // Prediction reads the registered BTB, so a same-cycle update is not visible until next fetch.
  assign fetch_hit  = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
  assign upd_hit    = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
  assign pred_taken = fetch_hit && btb_ctr_q[fetch_idx][1];
  assign pc_plus2   = pc_q + PC_INC;
  assign pred_next  = pred_taken ? btb_target_q[fetch_idx] : pc_plus2;

  always_comb begin
    pc_d = pc_q;
    if (update_PC) begin
      pc_d = actual_target;
    end else if (!PC_stall) begin
      pc_d = pred_next;
    end

    if_id_pc_d          = if_id_pc_q;
    if_id_pc2_d         = if_id_pc2_q;
    if_id_instr_d       = if_id_instr_q;
    if_id_pred_taken_d  = if_id_pred_taken_q;
    if_id_pred_target_d = if_id_pred_target_q;
    if (IF_flush) begin
      if_id_pc_d          = '0;
      if_id_pc2_d         = '0;
      if_id_instr_d       = NOP_INSTR;
      if_id_pred_taken_d  = 1'b0;
      if_id_pred_target_d = '0;
    end else if (!IF_ID_stall) begin
      if_id_pc_d          = pc_q;
      if_id_pc2_d         = pc_plus2;
      if_id_instr_d       = imem_instr;
      if_id_pred_taken_d  = pred_taken;
      if_id_pred_target_d = pred_next;
    end

    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_ctr_d    = btb_ctr_q;
    if (ID_branch_valid) begin
      btb_target_d[upd_idx] = ID_branch_target;
      if (upd_hit) begin
        if (ID_taken) begin
          if (btb_ctr_q[upd_idx] != 2'b11) btb_ctr_d[upd_idx] = btb_ctr_q[upd_idx] + 2'b01;
        end else begin
          if (btb_ctr_q[upd_idx] != 2'b00) btb_ctr_d[upd_idx] = btb_ctr_q[upd_idx] - 2'b01;
        end
      end else begin
        btb_valid_d[upd_idx] = 1'b1;
        btb_tag_d[upd_idx]   = upd_tag;
        btb_ctr_d[upd_idx]   = ID_taken ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q                <= RESET_PC;
      if_id_pc_q          <= '0;
      if_id_pc2_q         <= '0;
      if_id_instr_q       <= NOP_INSTR;
      if_id_pred_taken_q  <= 1'b0;
      if_id_pred_target_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q                <= pc_d;
      if_id_pc_q          <= if_id_pc_d;
      if_id_pc2_q         <= if_id_pc2_d;
      if_id_instr_q       <= if_id_instr_d;
      if_id_pred_taken_q  <= if_id_pred_taken_d;
      if_id_pred_target_q <= if_id_pred_target_d;
      btb_valid_q         <= btb_valid_d;
      btb_tag_q           <= btb_tag_d;
      btb_target_q        <= btb_target_d;
      btb_ctr_q           <= btb_ctr_d;
    end
  end

  assign imem_addr         = pc_q;
  assign IF_ID_PC          = if_id_pc_q;
  assign IF_ID_PC_plus2    = if_id_pc2_q;
  assign IF_ID_instr       = if_id_instr_q;
  assign IF_ID_pred_taken  = if_id_pred_taken_q;
  assign IF_ID_pred_target = if_id_pred_target_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for reset/stall/redirect, scoreboarded sequences for BTB behaviour.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, PC_stall, IF_ID_stall, IF_flush, update_PC;
  logic        ID_branch_valid, ID_taken;
  logic [15:0] actual_target, ID_PC, ID_branch_target;
  logic [15:0] imem_instr, imem_addr;
  logic [15:0] IF_ID_PC, IF_ID_PC_plus2, IF_ID_instr, IF_ID_pred_target;
  logic        IF_ID_pred_taken;

  always #5 clk = ~clk;

  assign imem_instr = 16'hA000 + imem_addr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
    .IF_flush(IF_flush), .update_PC(update_PC), .actual_target(actual_target),
    .ID_branch_valid(ID_branch_valid), .ID_PC(ID_PC), .ID_taken(ID_taken),
    .ID_branch_target(ID_branch_target), .imem_instr(imem_instr),
    .imem_addr(imem_addr), .IF_ID_PC(IF_ID_PC), .IF_ID_PC_plus2(IF_ID_PC_plus2),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pred_taken(IF_ID_pred_taken),
    .IF_ID_pred_target(IF_ID_pred_target)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] instr;
    logic        pt;
    logic [15:0] ptgt;
  } ifid_t;

  typedef struct {
    logic        rst, ps, is, fl, up;
    logic [15:0] tgt, e_addr, e_pc, e_instr, e_pc2;
  } vec_t;

  ifid_t       sb[$];
  vec_t        vt[13];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm);
    ifid_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, ".pc"},    {16'h0, IF_ID_PC},          {16'h0, e.pc});
    chk({nm, ".pc2"},   {16'h0, IF_ID_PC_plus2},    {16'h0, e.pc2});
    chk({nm, ".instr"}, {16'h0, IF_ID_instr},       {16'h0, e.instr});
    chk({nm, ".pt"},    {31'h0, IF_ID_pred_taken},  {31'h0, e.pt});
    chk({nm, ".ptgt"},  {16'h0, IF_ID_pred_target}, {16'h0, e.ptgt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; PC_stall = 0; IF_ID_stall = 0; IF_flush = 0; update_PC = 0;
    actual_target = 0; ID_branch_valid = 0; ID_PC = 0; ID_taken = 0; ID_branch_target = 0;
  endtask

  task automatic set_branch(input logic bv, input logic [15:0] bpc, input logic btk,
                            input logic [15:0] btgt);
    ID_branch_valid = bv; ID_PC = bpc; ID_taken = btk; ID_branch_target = btgt;
  endtask

  // Redirect with flush, optionally resolving a branch in the same cycle.
  task automatic redirect(input string nm, input logic [15:0] tgt, input logic bv,
                          input logic [15:0] bpc, input logic btk, input logic [15:0] btgt);
    update_PC = 1; actual_target = tgt; IF_flush = 1;
    set_branch(bv, bpc, btk, btgt);
    sb.push_back('{16'h0, 16'h0, 16'h0000, 1'b0, 16'h0});
    tick();
    idle();
    chk({nm, ".addr"}, {16'h0, imem_addr}, {16'h0, tgt});
    pop_chk(nm);
    exp_pc = tgt;
  endtask

  // One free-running fetch; ptgt is the expected predicted next PC.
  task automatic fetch(input string nm, input logic pt, input logic [15:0] ptgt, input logic bv,
                       input logic [15:0] bpc, input logic btk, input logic [15:0] btgt);
    logic [15:0] p2;
    p2 = exp_pc + 16'd2;
    set_branch(bv, bpc, btk, btgt);
    sb.push_back('{exp_pc, p2, 16'hA000 + exp_pc, pt, ptgt});
    tick();
    idle();
    pop_chk(nm);
    chk({nm, ".addr"}, {16'h0, imem_addr}, {16'h0, ptgt});
    exp_pc = ptgt;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    //          rst ps is fl up tgt       addr      if_pc     instr     pc2
    vt[0]  = '{1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'hA000, 16'h0002};
    vt[2]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'hA002, 16'h0004};
    vt[3]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'hA004, 16'h0006};
    vt[4]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'hA006, 16'h0008};
    vt[5]  = '{0, 1, 1, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'hA006, 16'h0008};
    vt[6]  = '{0, 1, 1, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'hA006, 16'h0008};
    vt[7]  = '{0, 1, 1, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'hA006, 16'h0008};
    vt[8]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h000A, 16'h0008, 16'hA008, 16'h000A};
    vt[9]  = '{0, 1, 0, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000};
    vt[10] = '{0, 0, 0, 0, 0, 16'h0000, 16'h0042, 16'h0040, 16'hA040, 16'h0042};
    vt[11] = '{0, 0, 1, 1, 0, 16'h0000, 16'h0044, 16'h0000, 16'h0000, 16'h0000};
    vt[12] = '{0, 0, 0, 0, 0, 16'h0000, 16'h0046, 16'h0044, 16'hA044, 16'h0046};

    idle();
    tick();
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; PC_stall = vt[i].ps; IF_ID_stall = vt[i].is;
      IF_flush = vt[i].fl; update_PC = vt[i].up; actual_target = vt[i].tgt;
      sb.push_back('{vt[i].e_pc, vt[i].e_pc2, vt[i].e_instr, 1'b0, vt[i].e_pc2});
      tick();
      idle();
      chk($sformatf("vec%0d.addr", i), {16'h0, imem_addr}, {16'h0, vt[i].e_addr});
      pop_chk($sformatf("vec%0d", i));
    end
    exp_pc = 16'h0046;

    // Allocate taken, then two not-taken steps: 10 -> 01 -> 00.
    redirect("alloc", 16'h0010, 1, 16'h0010, 1, 16'h0080);
    fetch("alloc_f", 1, 16'h0080, 0, 0, 0, 0);
    redirect("nt1", 16'h0010, 1, 16'h0010, 0, 16'h0080);
    fetch("nt1_f", 0, 16'h0012, 0, 0, 0, 0);
    redirect("nt2", 16'h0010, 1, 16'h0010, 0, 16'h0080);
    fetch("nt2_f", 0, 16'h0012, 0, 0, 0, 0);

    // From 00, four taken saturate at 11; one not-taken leaves 10 (still taken).
    for (int k = 0; k < 4; k++) redirect($sformatf("tk%0d", k), 16'h0010, 1, 16'h0010, 1, 16'h0080);
    fetch("sat_f", 1, 16'h0080, 0, 0, 0, 0);
    redirect("sat_nt", 16'h0010, 1, 16'h0010, 0, 16'h0080);
    fetch("sat_nt_f", 1, 16'h0080, 0, 0, 0, 0);

    // Aliased index with different tag misses; PC+2 wraps at the top.
    redirect("alias", 16'h0020, 0, 0, 0, 0);
    fetch("alias_f", 0, 16'h0022, 0, 0, 0, 0);
    redirect("wrap", 16'hFFFE, 0, 0, 0, 0);
    fetch("wrap_f", 0, 16'h0000, 0, 0, 0, 0);

    // Update and fetch of the same entry in one cycle: fetch sees the old (empty) entry.
    redirect("same", 16'h0034, 0, 0, 0, 0);
    fetch("same_f", 0, 16'h0036, 1, 16'h0034, 1, 16'h0090);
    redirect("same2", 16'h0034, 0, 0, 0, 0);
    fetch("same2_f", 1, 16'h0090, 0, 0, 0, 0);

    // Reset mid-run beats a redirect and clears the BTB.
    rst = 1; update_PC = 1; actual_target = 16'h0050;
    set_branch(1, 16'h0010, 1, 16'h0080);
    sb.push_back('{16'h0, 16'h0, 16'h0000, 1'b0, 16'h0});
    tick();
    idle();
    chk("mid_rst.addr", {16'h0, imem_addr}, 32'h0);
    pop_chk("mid_rst");
    exp_pc = 16'h0000;
    redirect("post_rst", 16'h0034, 0, 0, 0, 0);
    fetch("post_rst_f", 0, 16'h0036, 0, 0, 0, 0);
    redirect("post_rst2", 16'h0010, 0, 0, 0, 0);
    fetch("post_rst2_f", 0, 16'h0012, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
